// File: rtl/iohub_pkg.sv
// Shared iohub types and constants: FSM state encoding, default sync byte and
// default inter-byte timeout, plus the checksum accumulation helper.
package iohub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_CHECK   = 2'b10
    } iohub_state_e;

    localparam logic [7:0] IOHUB_SYNC_DEFAULT    = 8'h80;
    localparam int         IOHUB_TIMEOUT_DEFAULT = 1024;

    // Modulo-256 running sum used by the optional frame checksum.
    function automatic logic [7:0] iohub_sum8(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/iohub_byte_timer.sv
// Saturating inter-byte timer: counts while run is high, clears on clear, and
// flags expiry when the count reaches a non-zero limit (limit 0 disables it).
module iohub_byte_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_r;
    logic             at_limit_s;

    assign at_limit_s = (cnt_r == limit_i);
    assign expired_o  = run_i & at_limit_s & (limit_i != {WIDTH{1'b0}});

    // Count register: clear wins, then count up to the limit and hold there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (run_i && !at_limit_s) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Collects SYNC-prefixed UART frames of BYTES payload bytes (MSB first) into a
// valid/ready holding register. Optional checksum byte: UART_FRAME_CHECKSUM_EN.
module uart_frame_assembler
    import iohub_pkg::*;
#(
    parameter int         BYTES       = 2,
    parameter logic [7:0] SYNC        = IOHUB_SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = IOHUB_TIMEOUT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         rx_byte_i,
    input  logic               rx_valid_i,
    input  logic               en_i,
    output logic [8*BYTES-1:0] word_o,
    output logic               word_valid_o,
    input  logic               word_ready_i,
    output logic               busy_o,
    output logic               err_o,
    output logic               ovf_o
);

    localparam int WW = 8 * BYTES;
    localparam int IW = $clog2(BYTES + 1);
    // A disabled timeout still needs a one-bit counter to stay legal.
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    iohub_state_e  state_r, state_s;
    logic [IW-1:0] idx_r, idx_s;
    logic [WW-1:0] shift_r, shift_s;
    logic [WW-1:0] word_r;
    logic [WW-1:0] frame_word_s;
    logic          frame_done_s;
    logic          word_valid_r;
    logic          busy_r;
    logic          err_r, err_s;
    logic          ovf_r;
    logic          accept_s;
    logic          expired_s;
    logic          load_s;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]    sum_r, sum_s;
`endif

    assign accept_s = rx_valid_i & en_i;
    assign load_s   = frame_done_s & (~word_valid_r | word_ready_i);

    iohub_byte_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (accept_s | (state_r == ST_IDLE)),
        .run_i     (state_r != ST_IDLE),
        .limit_i   (TW'(TIMEOUT_CYC)),
        .expired_o (expired_s)
    );

    // Next-state, shift/index update, frame completion and error decode.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        shift_s      = shift_r;
        frame_word_s = shift_r;
        frame_done_s = 1'b0;
        err_s        = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_s        = sum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (rx_byte_i == SYNC)) begin
                    state_s = ST_PAYLOAD;
                    idx_s   = {IW{1'b0}};
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_s   = 8'h00;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (!en_i) begin
                    state_s = ST_IDLE;
                end else if (rx_valid_i) begin
                    // SYNC seen here is ordinary payload data.
                    shift_s = (shift_r << 8) | WW'(rx_byte_i);
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_s   = iohub_sum8(sum_r, rx_byte_i);
`endif
                    if (idx_r == IW'(BYTES - 1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_s      = ST_CHECK;
`else
                        state_s      = ST_IDLE;
                        frame_done_s = 1'b1;
                        frame_word_s = shift_s;
`endif
                    end else begin
                        idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end else if (expired_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (!en_i) begin
                    state_s = ST_IDLE;
                end else if (rx_valid_i) begin
                    state_s = ST_IDLE;
                    if (rx_byte_i == sum_r) begin
                        frame_done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (expired_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_CHECK;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, byte index, shift register and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            shift_r <= {WW{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            busy_r  <= (state_s != ST_IDLE);
            err_r   <= err_s;
            ovf_r   <= frame_done_s & word_valid_r & ~word_ready_i;
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    // Running payload checksum.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_r <= 8'h00;
        end else begin
            sum_r <= sum_s;
        end
    end
`endif

    // Holding register: a completing frame may load in the same cycle a drain happens.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_r       <= {WW{1'b0}};
            word_valid_r <= 1'b0;
        end else if (load_s) begin
            word_r       <= frame_word_s;
            word_valid_r <= 1'b1;
        end else if (word_valid_r && word_ready_i) begin
            word_r       <= word_r;
            word_valid_r <= 1'b0;
        end else begin
            word_r       <= word_r;
            word_valid_r <= word_valid_r;
        end
    end

    assign word_o       = word_r;
    assign word_valid_o = word_valid_r;
    assign busy_o       = busy_r;
    assign err_o        = err_r;
    assign ovf_o        = ovf_r;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler (BYTES=2, TIMEOUT_CYC=16); the
// checksum scenarios are built when UART_FRAME_CHECKSUM_EN is defined.
module tb_uart_frame_assembler;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        en;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        err;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int exp_err = 0;
    logic [15:0] exp_q[$];

    uart_frame_assembler #(
        .BYTES       (2),
        .SYNC        (8'h80),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_byte_i    (rx_byte),
        .rx_valid_i   (rx_valid),
        .en_i         (en),
        .word_o       (word),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .busy_o       (busy),
        .err_o        (err),
        .ovf_o        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts status pulses and scores every accepted word.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_seen++;
            if (ovf) ovf_seen++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", word);
                end else begin
                    check("word", {16'h0, word}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tick(1);
    endtask

    task automatic send_frame(input logic [15:0] w, input bit expect_word);
        logic [7:0] cs;
        cs = w[15:8] + w[7:0];
        if (expect_word) exp_q.push_back(w);
        send_byte(8'h80);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
`ifdef UART_FRAME_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    initial begin
        int err0;
        rst = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; en = 1'b1; word_ready = 1'b1;
        tick(3);
        check("rst_word", {16'h0, word}, 32'h0);
        check("rst_valid", {31'h0, word_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Basic frame
        send_frame(16'h1234, 1'b1);
        tick(2);
        check("basic_busy", {31'h0, busy}, 32'h0);
        check("basic_valid_cleared", {31'h0, word_valid}, 32'h0);

        // Noise byte, then SYNC value used as payload
        send_byte(8'h55);
        check("noise_busy", {31'h0, busy}, 32'h0);
        send_frame(16'h80AB, 1'b1);
        tick(2);

        // Timeout
        err0 = err_seen;
        send_byte(8'h80);
        send_byte(8'h12);
        tick(10);
        check("timeout_not_early_busy", {31'h0, busy}, 32'h1);
        check("timeout_not_early_err", err_seen, err0);
        for (int i = 0; i < 40 && err_seen == err0; i++) tick(1);
        exp_err++;
        tick(3);
        check("timeout_err_count", err_seen, exp_err);
        check("timeout_busy", {31'h0, busy}, 32'h0);
        send_frame(16'h5678, 1'b1);
        tick(2);

        // Overflow
        word_ready = 1'b0;
        send_frame(16'h1111, 1'b1);
        send_frame(16'h2222, 1'b0);
        tick(2);
        check("ovf_count", ovf_seen, 1);
        check("ovf_word_held", {16'h0, word}, 32'h1111);
        check("ovf_valid", {31'h0, word_valid}, 32'h1);
        word_ready = 1'b1;
        tick(2);
        check("ovf_drained", {31'h0, word_valid}, 32'h0);

`ifdef UART_FRAME_CHECKSUM_EN
        // Bad checksum
        send_byte(8'h80);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h47);
        exp_err++;
        tick(2);
        check("cs_err_count", err_seen, exp_err);
        check("cs_no_word", {31'h0, word_valid}, 32'h0);
        send_frame(16'h0FF1, 1'b1);
        tick(2);
`endif

        // Asynchronous reset mid-frame with a held word
        word_ready = 1'b0;
        send_frame(16'h9ABC, 1'b0);
        send_byte(8'h80);
        send_byte(8'h12);
        #3 rst = 1'b1;
        #1;
        check("arst_word", {16'h0, word}, 32'h0);
        check("arst_valid", {31'h0, word_valid}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        tick(1);
        rst = 1'b0;
        word_ready = 1'b1;
        tick(2);

        // Enable abort
        send_byte(8'h80);
        send_byte(8'h12);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        check("en_abort_busy", {31'h0, busy}, 32'h0);
        check("en_abort_no_err", err_seen, exp_err);
        send_frame(16'hCDEF, 1'b1);
        tick(4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Parametrised successor to the iohub byte-to-word header logic. Watches the UART receiver's byte stream for a configurable sync byte, collects `BYTES` payload bytes MSB-first into one word, and offers it to the bus side through a valid/ready holding register. It adds inter-byte timeout, overflow reporting and an optional checksum byte. It is fully synchronous to `clk_i`; no logic is clocked by the receiver strobe.

## Interface
Parameters:
- `BYTES`, default 2: payload bytes per frame, legal range 1..8.
- `SYNC`, default 8'h80: frame start byte.
- `TIMEOUT_CYC`, default 1024: maximum `clk_i` cycles between bytes of one frame; 0 disables the timeout.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `rx_byte_i` input 8: received byte, valid while `rx_valid_i` is high.
- `rx_valid_i` input 1: one-cycle strobe per received byte.
- `en_i` input 1: assembly enable, driven by `we_i & stb_i` upstream.
- `word_o` output 8*BYTES: assembled word; the first payload byte occupies the MSBs.
- `word_valid_o` output 1: `word_o` holds an unconsumed frame.
- `word_ready_i` input 1: consumer accepts `word_o` in a cycle where valid and ready are both high.
- `busy_o` output 1: a frame is in progress (state is not IDLE).
- `err_o` output 1: one-cycle pulse on timeout or checksum failure.
- `ovf_o` output 1: one-cycle pulse when a completed frame is dropped because the holding register is full.

## Operation
- **States** (2-bit encoding): IDLE, PAYLOAD, CHECK. CHECK exists only with the checksum macro.
- **IDLE**: a byte is accepted when `rx_valid_i & en_i`.
  - Byte equals `SYNC`: clear the byte index, go to PAYLOAD.
  - Any other byte: discard.
- **PAYLOAD**: each accepted byte shifts into the shift register, and the byte index increments.
  - On byte index `BYTES-1`, the frame is complete: go to CHECK if the macro is defined, otherwise to IDLE.
  - A `SYNC` value inside the payload is data; the block does not re-synchronise on it.
- **Frame complete (load rule)**:
  - Holding register empty, or drained in the same cycle: load it, set `word_valid_o`.
  - Otherwise: keep the held word unchanged, drop the new frame, pulse `ovf_o`.
- **Draining**: `word_valid_o` clears on a valid & ready cycle unless a new word loads in that same cycle. Back-to-back frames therefore need no idle cycle.
- **`en_i` low**: bytes are ignored. If `en_i` is low in PAYLOAD or CHECK, the frame aborts to IDLE on the next edge with no `err_o` pulse.
- **Timeout**:
  - The counter is cleared on every accepted byte and counts while `busy_o` is high.
  - When it reaches `TIMEOUT_CYC`, the frame aborts to IDLE and `err_o` pulses.
  - If a byte arrives in the same cycle the counter expires, the byte wins and the counter clears.
- **Reset**: an asynchronous reset mid-frame discards the partial frame and any held word.

## Timing
- **Reset values**: state IDLE, `word_o` 0, `word_valid_o` 0, `busy_o` 0, `err_o` 0, `ovf_o` 0, counters 0.
- **Frame latency**: `word_valid_o` and `word_o` update on the edge after the clock that samples the last payload byte (or the checksum byte).
- **`busy_o`**: high from the edge after SYNC is accepted until the edge after completion or abort.
- **Pulses**: `err_o` and `ovf_o` are registered, exactly one cycle wide, and appear on the same edge as the state return to IDLE.
- **`word_o`**: stable while `word_valid_o` is high and the word has not been accepted.
- **Counter widths**: byte index is `$clog2(BYTES+1)` bits; timeout counter is `$clog2(TIMEOUT_CYC+1)` bits. Neither counter wraps; both saturate or clear.

## Configuration
- **`UART_FRAME_CHECKSUM_EN` defined**:
  - After the payload, one extra byte is expected in CHECK.
  - The block keeps a running 8-bit modulo-256 sum of all payload bytes; SYNC is excluded.
  - Received byte equals the sum: apply the load rule.
  - Mismatch: drop the frame, pulse `err_o`.
  - Timeout and `en_i` abort also apply in CHECK.
- **Not defined**: CHECK and the sum register are absent, and frames complete on the last payload byte.

## Structure
- **Package `iohub_pkg`**:
  - state enum (IDLE=2'b00, PAYLOAD=2'b01, CHECK=2'b10);
  - `IOHUB_SYNC_DEFAULT` = 8'h80;
  - `IOHUB_TIMEOUT_DEFAULT` = 1024.
- **Sub-module `iohub_byte_timer`**: the timeout counter, with inputs clear, run and limit, and output expired. The iohub UART transmitter reuses it.

## Test plan
- **Basic frame**: BYTES=2, stream 0x80, 0x12, 0x34 with `en_i`=1 and `word_ready_i`=1 → `word_o`=16'h1234, `word_valid_o` high for one cycle, `busy_o` low afterwards.
- **Noise and embedded SYNC**: 0x55, 0x80, 0x80, 0xAB → 0x55 is ignored and `word_o`=16'h80AB.
- **Timeout**: TIMEOUT_CYC=16, send 0x80, 0x12, then wait 16 cycles → `err_o` pulses once, state returns to IDLE, and the next valid frame assembles correctly.
- **Overflow**: `word_ready_i`=0, send two frames 0x1111 and 0x2222 → `ovf_o` pulses at the second completion and `word_o` stays 16'h1111. Raising `word_ready_i` then drains it.
- **Checksum**: with the macro defined, 0x80, 0x12, 0x34, 0x46 → word 16'h1234. 0x80, 0x12, 0x34, 0x47 → `err_o` pulses and `word_valid_o` stays 0.
- **Reset and enable abort**: assert `rst_i` after 0x80, 0x12 → all outputs return to their reset values immediately. Separately, drop `en_i` mid-frame → abort with no `err_o` pulse.
